// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller slice.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Classification of an accepted BCD word.
  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_BLOCKED,
    CLS_BLANK,
    CLS_ERR
  } bcd_class_t;

  localparam logic [3:0] BCD_BLOCKED_NIB = 4'hA;
  localparam logic [3:0] BCD_BLANK_NIB   = 4'hF;
  localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Input/output handshake bundle of the BCD-to-binary converter.
interface bcd_to_binary_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_blocked;
  logic                  out_blank;
  logic                  out_err;

  // Producer of BCD words and consumer of results.
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_blocked, out_blank, out_err
  );

  // The converter itself.
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_blocked, out_blank, out_err
  );
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction cell: subtract 3 from a digit that is 8 or more.
module bcd_digit_sub3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // Combinational adjust of one shifted BCD digit.
  always_comb begin
    q = d;
    if (d >= 4'd8) q = d - 4'd3;
  end
endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one step per clock)
// with sentinel pass-through flags and valid/ready handshakes.
module bcd_to_binary
  import traffic_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic             clk,
  input logic             rst,
  bcd_to_binary_if.slave  bus
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t              state;
  bcd_class_t          cls;
  bcd_class_t          in_class;
  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     shifted;
  logic [SR_W-1:0]     sr_next;
  logic [4*DIGITS-1:0] adj_bcd;
  logic [CNT_W-1:0]    cnt;

  logic                in_ready_r;
  logic                out_valid_r;
  logic [BIN_W-1:0]    out_bin_r;
  logic                out_blocked_r;
  logic                out_blank_r;
  logic                out_err_r;

  logic                all_blocked;
  logic                all_blank;
  logic                any_high;

  // Classify the presented word: sentinels first, then out-of-range digits.
  always_comb begin
    all_blocked = 1'b1;
    all_blank   = 1'b1;
    any_high    = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.in_bcd[4*i +: 4] != BCD_BLOCKED_NIB) all_blocked = 1'b0;
      if (bus.in_bcd[4*i +: 4] != BCD_BLANK_NIB)   all_blank   = 1'b0;
      if (bus.in_bcd[4*i +: 4] >  BCD_MAX_DIGIT)   any_high    = 1'b1;
    end
    if (all_blocked)    in_class = CLS_BLOCKED;
    else if (all_blank) in_class = CLS_BLANK;
    else if (any_high)  in_class = CLS_ERR;
    else                in_class = CLS_NUM;
  end

  assign shifted = sr >> 1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
        .d (shifted[BIN_W + 4*g +: 4]),
        .q (adj_bcd[4*g +: 4])
      );
    end
  endgenerate

  assign sr_next = {adj_bcd, shifted[BIN_W-1:0]};

  // Control FSM, shift register, iteration counter and registered outputs.
  // Sentinel/error words also pass through CONV for a single cycle with a zero
  // register, so their result appears one edge after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cls           <= CLS_NUM;
      sr            <= '0;
      cnt           <= '0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      out_bin_r     <= '0;
      out_blocked_r <= 1'b0;
      out_blank_r   <= 1'b0;
      out_err_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= CONV;
            in_ready_r <= 1'b0;
            cls        <= in_class;
            if (in_class == CLS_NUM) begin
              sr  <= {bus.in_bcd, {BIN_W{1'b0}}};
              cnt <= CNT_W'(BIN_W);
            end else begin
              sr  <= '0;
              cnt <= CNT_W'(1);
            end
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            out_valid_r   <= 1'b1;
            out_bin_r     <= (cls == CLS_NUM) ? sr_next[BIN_W-1:0] : '0;
            out_blocked_r <= (cls == CLS_BLOCKED);
            out_blank_r   <= (cls == CLS_BLANK);
            out_err_r     <= (cls == CLS_ERR);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_bin_r     <= '0;
            out_blocked_r <= 1'b0;
            out_blank_r   <= 1'b0;
            out_err_r     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_bin     = out_bin_r;
  assign bus.out_blocked = out_blocked_r;
  assign bus.out_blank   = out_blank_r;
  assign bus.out_err     = out_err_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary.
module tb_bcd_to_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.out_err, bus.out_blank, bus.out_blocked};
  endfunction

  // Present a word for one edge; caller guarantees in_ready is high.
  task automatic accept(input logic [15:0] bcd);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen; 0 means it never came.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (bus.out_valid) lat = i;
      end
    end
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val({tag, "_valid_clr"}, bus.out_valid, 0);
    check_val({tag, "_ready_set"}, bus.in_ready, 1);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] bcd, input int exp_bin,
                         input int exp_lat, input logic [2:0] exp_flags);
    int lat;
    accept(bcd);
    check_val({tag, "_busy"}, bus.in_ready, 0);
    wait_out(lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_bin"}, bus.out_bin, exp_bin);
    check_val({tag, "_flags"}, flags(), exp_flags);
    handshake(tag);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] bcd;
    int          bin;
    int          lat;
    logic [2:0]  fl;   // {err, blank, blocked}
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int seen;

    vecs[0] = '{"v0042", 16'h0042,   42, 14, 3'b000};
    vecs[1] = '{"v0000", 16'h0000,    0, 14, 3'b000};
    vecs[2] = '{"v9999", 16'h9999, 9999, 14, 3'b000};
    vecs[3] = '{"v1000", 16'h1000, 1000, 14, 3'b000};
    vecs[4] = '{"vAAAA", 16'hAAAA,    0,  1, 3'b001};
    vecs[5] = '{"vFFFF", 16'hFFFF,    0,  1, 3'b010};
    vecs[6] = '{"v12A4", 16'h12A4,    0,  1, 3'b100};
    vecs[7] = '{"vAAAB", 16'hAAAB,    0,  1, 3'b100};

    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_val("rst_in_ready",  bus.in_ready,  1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_bin",   bus.out_bin,   0);
    check_val("rst_flags",     flags(),       0);

    foreach (vecs[i]) run_vec(vecs[i].tag, vecs[i].bcd, vecs[i].bin, vecs[i].lat, vecs[i].fl);

    // out_ready already high: handshake on the first DONE edge.
    bus.out_ready = 1'b1;
    accept(16'h0010);
    wait_out(lat);
    check_val("pre_rdy_lat", lat, 14);
    check_val("pre_rdy_bin", bus.out_bin, 10);
    @(posedge clk); #1;
    check_val("pre_rdy_clr", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Backpressure with a second word waiting.
    accept(16'h0123);
    wait_out(lat);
    check_val("bp_lat", lat, 14);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h0055;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_val("bp_hold_valid", bus.out_valid, 1);
      check_val("bp_hold_bin",   bus.out_bin,   123);
      check_val("bp_hold_rdy",   bus.in_ready,  0);
    end
    handshake("bp");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("bp_next_taken", bus.in_ready, 0);
    wait_out(lat);
    check_val("bp_next_lat", lat, 14);
    check_val("bp_next_bin", bus.out_bin, 55);
    handshake("bp_next");

    // Reset on the 5th CONV step of 0x0099.
    accept(16'h0099);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_ready", bus.in_ready,  1);
    check_val("mid_rst_valid", bus.out_valid, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_val("mid_rst_no_result", seen, 0);
    run_vec("after_rst", 16'h0007, 7, 14, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
